// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter that shares one data-memory port
// between three requesters (core load/store, DMA, debug). It drives the
// select of the 3-to-1 data mux, a one-hot grant and the memory enable,
// holds the grant until the memory acknowledges, then pulses a
// per-requester done for one cycle.
//
// Optional feature: define ARB_TIMEOUT_EN to abort a BUSY phase that has
// waited TIMEOUT cycles without mem_ack_i. The abort ends in DONE with
// done_o=0 and a one-cycle err_o pulse. Without the macro, BUSY waits
// indefinitely and err_o is constant 0.
//
// Every output is registered. The state register and all output registers
// load together from a single next-state/next-output process.

module mem_port_arbiter #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] req_i,
  input  logic       mem_ack_i,
  output logic [1:0] sel_o,
  output logic [2:0] gnt_o,
  output logic       mem_en_o,
  output logic [2:0] done_o,
  output logic       busy_o,
  output logic       err_o
);

  // The timeout counter must be able to represent TIMEOUT.
  if ((2 ** CNT_W) <= TIMEOUT) begin : g_bad_cfg
    $error("mem_port_arbiter: CNT_W too narrow for TIMEOUT");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [1:0] ptr, ptr_n;
  logic [1:0] sel_n;
  logic [2:0] gnt_n;
  logic       mem_en_n;
  logic [2:0] done_n;
  logic       busy_n;
  logic       err_n;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt, cnt_n;
`endif

  // Modulo-3 increment; an index or pointer never holds 3.
  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // First requester set, searching ptr, ptr+1, ptr+2 (mod 3).
  // Only meaningful when req is non-zero.
  function automatic logic [1:0] pick(input logic [2:0] req,
                                      input logic [1:0] start);
    logic [1:0] c0, c1, c2;
    c0 = start;
    c1 = inc3(c0);
    c2 = inc3(c1);
    if (req[c0])      return c0;
    else if (req[c1]) return c1;
    else              return c2;
  endfunction

  // Index to one-hot grant/done vector.
  function automatic logic [2:0] onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  // State and output registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      sel_o    <= 2'd0;
      gnt_o    <= 3'b000;
      mem_en_o <= 1'b0;
      done_o   <= 3'b000;
      busy_o   <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      sel_o    <= sel_n;
      gnt_o    <= gnt_n;
      mem_en_o <= mem_en_n;
      done_o   <= done_n;
      busy_o   <= busy_n;
      err_o    <= err_n;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Timeout counter register, cleared on BUSY entry by the next-state logic.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt <= '0;
    else       cnt <= cnt_n;
  end
`endif

  // Next-state and next-output logic.
  // NOTE: every variable gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    sel_n    = sel_o;
    gnt_n    = gnt_o;
    mem_en_n = mem_en_o;
    done_n   = 3'b000;
    err_n    = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_n    = cnt;
`endif

    unique case (state)
      IDLE: begin
        // sel holds its last value while idle; grant and enable stay low.
        gnt_n    = 3'b000;
        mem_en_n = 1'b0;
        if (req_i != 3'b000) begin
          sel_n    = pick(req_i, ptr);
          gnt_n    = onehot(pick(req_i, ptr));
          mem_en_n = 1'b1;
          state_n  = BUSY;
`ifdef ARB_TIMEOUT_EN
          cnt_n    = '0;
`endif
        end
      end

      BUSY: begin
        // sel_o carries the granted index for the whole BUSY phase.
        // An ack on the same cycle as the timeout takes priority.
        if (mem_ack_i) begin
          gnt_n    = 3'b000;
          mem_en_n = 1'b0;
          done_n   = onehot(sel_o);
          ptr_n    = inc3(sel_o);
          state_n  = DONE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT)) begin
          gnt_n    = 3'b000;
          mem_en_n = 1'b0;
          err_n    = 1'b1;
          ptr_n    = inc3(sel_o);
          state_n  = DONE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
`endif
      end

      DONE: begin
        // done_o/err_o were set on entry and drop here; acks are ignored.
        state_n = IDLE;
      end

      default: begin
        state_n  = IDLE;
        gnt_n    = 3'b000;
        mem_en_n = 1'b0;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Inputs change 1 time unit after
// each rising edge and outputs are sampled at that same point, so every
// sample reflects the registers loaded at the preceding edge.
// Each comparison packs {sel, gnt, mem_en, done, busy, err}.

module tb_mem_port_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [2:0] req_i = 3'b000;
  logic       mem_ack_i = 1'b0;
  logic [1:0] sel_o;
  logic [2:0] gnt_o;
  logic       mem_en_o;
  logic [2:0] done_o;
  logic       busy_o;
  logic       err_o;

  int vectors = 0;
  int miscompares = 0;

  mem_port_arbiter #(.TIMEOUT(15), .CNT_W(4)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .mem_ack_i (mem_ack_i),
    .sel_o     (sel_o),
    .gnt_o     (gnt_o),
    .mem_en_o  (mem_en_o),
    .done_o    (done_o),
    .busy_o    (busy_o),
    .err_o     (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [10:0] obs();
    return {sel_o, gnt_o, mem_en_o, done_o, busy_o, err_o};
  endfunction

  function automatic logic [10:0] pk(input logic [1:0] s, input logic [2:0] g,
                                     input logic e, input logic [2:0] d,
                                     input logic b, input logic r);
    return {s, g, e, d, b, r};
  endfunction

  task automatic test_reset();
    logic [10:0] exp;
    rst_i = 1'b1;
    tick();
    tick();
    exp = pk(2'd0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
    vectors++;
    if (obs() !== exp) begin
      $display("FAIL reset_held: got %b expected %b", obs(), exp);
      miscompares++;
    end
    rst_i = 1'b0;
    tick();
    vectors++;
    if (obs() !== exp) begin
      $display("FAIL reset_idle: got %b expected %b", obs(), exp);
      miscompares++;
    end
  endtask

  // ptr starts at 0: grants rotate 0,1,2,0,1,2 with all three requesting.
  task automatic test_fairness();
    logic [10:0] exp;
    req_i = 3'b111;
    for (int i = 0; i < 6; i++) begin
      logic [1:0] k;
      k = 2'(i % 3);
      tick();
      exp = pk(k, 3'b001 << k, 1'b1, 3'b000, 1'b1, 1'b0);
      vectors++;
      if (obs() !== exp) begin
        $display("FAIL fair_grant%0d: got %b expected %b", i, obs(), exp);
        miscompares++;
      end
      mem_ack_i = 1'b1;
      tick();
      exp = pk(k, 3'b000, 1'b0, 3'b001 << k, 1'b1, 1'b0);
      vectors++;
      if (obs() !== exp) begin
        $display("FAIL fair_done%0d: got %b expected %b", i, obs(), exp);
        miscompares++;
      end
      mem_ack_i = 1'b0;
      tick();
      exp = pk(k, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
      vectors++;
      if (obs() !== exp) begin
        $display("FAIL fair_idle%0d: got %b expected %b", i, obs(), exp);
        miscompares++;
      end
    end
    req_i = 3'b000;
  endtask

  // Requester 1 alone; mem_en high for 3 cycles; ack held through DONE
  // (ignored there) and into IDLE (ignored there too). Leaves ptr=2, sel=1.
  task automatic test_single();
    logic [10:0] exp;
    req_i = 3'b010;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp = pk(2'd1, 3'b010, 1'b1, 3'b000, 1'b1, 1'b0);
      vectors++;
      if (obs() !== exp) begin
        $display("FAIL single_busy%0d: got %b expected %b", i, obs(), exp);
        miscompares++;
      end
    end
    mem_ack_i = 1'b1;
    tick();
    exp = pk(2'd1, 3'b000, 1'b0, 3'b010, 1'b1, 1'b0);
    vectors++;
    if (obs() !== exp) begin
      $display("FAIL single_done: got %b expected %b", obs(), exp);
      miscompares++;
    end
    req_i = 3'b000;
    tick();
    exp = pk(2'd1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
    vectors++;
    if (obs() !== exp) begin
      $display("FAIL single_idle: got %b expected %b", obs(), exp);
      miscompares++;
    end
    tick();
    vectors++;
    if (obs() !== exp) begin
      $display("FAIL ack_in_idle: got %b expected %b", obs(), exp);
      miscompares++;
    end
    mem_ack_i = 1'b0;
  endtask

  // ptr=2, req=001 -> grant 0; drop it and raise req 2 during BUSY.
  // done still 001, ptr becomes 1, next grant is 2. Ends in BUSY on 2.
  task automatic test_drop_contender();
    logic [10:0] exp;
    req_i = 3'b001;
    tick();
    exp = pk(2'd0, 3'b001, 1'b1, 3'b000, 1'b1, 1'b0);
    vectors++;
    if (obs() !== exp) begin
      $display("FAIL drop_grant0: got %b expected %b", obs(), exp);
      miscompares++;
    end
    req_i = 3'b100;
    tick();
    vectors++;
    if (obs() !== exp) begin
      $display("FAIL drop_busy: got %b expected %b", obs(), exp);
      miscompares++;
    end
    mem_ack_i = 1'b1;
    tick();
    exp = pk(2'd0, 3'b000, 1'b0, 3'b001, 1'b1, 1'b0);
    vectors++;
    if (obs() !== exp) begin
      $display("FAIL drop_done: got %b expected %b", obs(), exp);
      miscompares++;
    end
    mem_ack_i = 1'b0;
    tick();
    exp = pk(2'd0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
    vectors++;
    if (obs() !== exp) begin
      $display("FAIL drop_idle: got %b expected %b", obs(), exp);
      miscompares++;
    end
    tick();
    exp = pk(2'd2, 3'b100, 1'b1, 3'b000, 1'b1, 1'b0);
    vectors++;
    if (obs() !== exp) begin
      $display("FAIL drop_next_grant2: got %b expected %b", obs(), exp);
      miscompares++;
    end
  endtask

  // Entered in BUSY with gnt=100. Mid-cycle reset clears everything at once,
  // no done follows, and ptr=0 makes req=101 grant requester 0.
  task automatic test_reset_mid_busy();
    logic [10:0] exp;
    logic [10:0] zero;
    zero = pk(2'd0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
    req_i = 3'b101;
    tick();
    exp = pk(2'd2, 3'b100, 1'b1, 3'b000, 1'b1, 1'b0);
    vectors++;
    if (obs() !== exp) begin
      $display("FAIL rstbusy_pre: got %b expected %b", obs(), exp);
      miscompares++;
    end
    #2;
    rst_i = 1'b1;
    #1;
    vectors++;
    if (obs() !== zero) begin
      $display("FAIL rstbusy_async: got %b expected %b", obs(), zero);
      miscompares++;
    end
    mem_ack_i = 1'b1;
    tick();
    vectors++;
    if (obs() !== zero) begin
      $display("FAIL rstbusy_no_done: got %b expected %b", obs(), zero);
      miscompares++;
    end
    mem_ack_i = 1'b0;
    rst_i = 1'b0;
    tick();
    exp = pk(2'd0, 3'b001, 1'b1, 3'b000, 1'b1, 1'b0);
    vectors++;
    if (obs() !== exp) begin
      $display("FAIL rstbusy_regrant0: got %b expected %b", obs(), exp);
      miscompares++;
    end
    req_i = 3'b000;
    mem_ack_i = 1'b1;
    tick();
    exp = pk(2'd0, 3'b000, 1'b0, 3'b001, 1'b1, 1'b0);
    vectors++;
    if (obs() !== exp) begin
      $display("FAIL rstbusy_done: got %b expected %b", obs(), exp);
      miscompares++;
    end
    mem_ack_i = 1'b0;
    tick();
  endtask

  // ptr=1. Ack coincident with the IDLE->BUSY edge is lost.
  // Completes on requester 1, leaving ptr=2.
  task automatic test_ack_on_entry();
    logic [10:0] exp;
    req_i = 3'b010;
    mem_ack_i = 1'b1;
    tick();
    exp = pk(2'd1, 3'b010, 1'b1, 3'b000, 1'b1, 1'b0);
    vectors++;
    if (obs() !== exp) begin
      $display("FAIL entry_grant: got %b expected %b", obs(), exp);
      miscompares++;
    end
    mem_ack_i = 1'b0;
    tick();
    vectors++;
    if (obs() !== exp) begin
      $display("FAIL entry_ack_lost: got %b expected %b", obs(), exp);
      miscompares++;
    end
    req_i = 3'b000;
    mem_ack_i = 1'b1;
    tick();
    exp = pk(2'd1, 3'b000, 1'b0, 3'b010, 1'b1, 1'b0);
    vectors++;
    if (obs() !== exp) begin
      $display("FAIL entry_done: got %b expected %b", obs(), exp);
      miscompares++;
    end
    mem_ack_i = 1'b0;
    tick();
  endtask

  // ptr=2, req=001 -> grant 0 and never ack.
  task automatic test_timeout();
    logic [10:0] exp;
    req_i = 3'b001;
    tick();
    exp = pk(2'd0, 3'b001, 1'b1, 3'b000, 1'b1, 1'b0);
    vectors++;
    if (obs() !== exp) begin
      $display("FAIL tmo_grant: got %b expected %b", obs(), exp);
      miscompares++;
    end
    req_i = 3'b000;
`ifdef ARB_TIMEOUT_EN
    // Counter 0 at grant; 15 more BUSY cycles, the 16th edge aborts.
    for (int i = 1; i <= 15; i++) begin
      tick();
      vectors++;
      if (obs() !== exp) begin
        $display("FAIL tmo_wait%0d: got %b expected %b", i, obs(), exp);
        miscompares++;
      end
    end
    tick();
    exp = pk(2'd0, 3'b000, 1'b0, 3'b000, 1'b1, 1'b1);
    vectors++;
    if (obs() !== exp) begin
      $display("FAIL tmo_err: got %b expected %b", obs(), exp);
      miscompares++;
    end
    req_i = 3'b011;
    tick();
    exp = pk(2'd0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
    vectors++;
    if (obs() !== exp) begin
      $display("FAIL tmo_idle: got %b expected %b", obs(), exp);
      miscompares++;
    end
    // ptr advanced to 1, so requester 1 wins over requester 0.
    tick();
    exp = pk(2'd1, 3'b010, 1'b1, 3'b000, 1'b1, 1'b0);
    vectors++;
    if (obs() !== exp) begin
      $display("FAIL tmo_next_grant: got %b expected %b", obs(), exp);
      miscompares++;
    end
    req_i = 3'b000;
    mem_ack_i = 1'b1;
    tick();
    exp = pk(2'd1, 3'b000, 1'b0, 3'b010, 1'b1, 1'b0);
    vectors++;
    if (obs() !== exp) begin
      $display("FAIL tmo_next_done: got %b expected %b", obs(), exp);
      miscompares++;
    end
    mem_ack_i = 1'b0;
    tick();
`else
    // Without the timeout, BUSY waits indefinitely with no err.
    for (int i = 1; i <= 40; i++) begin
      tick();
      vectors++;
      if (obs() !== exp) begin
        $display("FAIL notmo_wait%0d: got %b expected %b", i, obs(), exp);
        miscompares++;
      end
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();
    exp = pk(2'd0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
    vectors++;
    if (obs() !== exp) begin
      $display("FAIL notmo_recover: got %b expected %b", obs(), exp);
      miscompares++;
    end
`endif
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_drop_contender();
    test_reset_mid_busy();
    test_ack_on_entry();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter that shares one data-memory port between three requesters.
- Drives the 2-bit select of the 3-to-1 data-memory mux (data0/1/2 paths), a one-hot grant and a memory enable.
- Holds the grant until the memory acknowledges, then pulses a per-requester done.
- Sits between the requesters (core load/store, DMA, debug) and the mux feeding data memory.

Parameters:
- TIMEOUT, 15: max cycles in BUSY waiting for mem_ack_i before abort; used only when the optional feature is compiled in.
- CNT_W, 4: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- req_i  input  3  level request; bit k is requester k, where k is the mux data input index.
- mem_ack_i  input  1  memory completion, 1-cycle pulse.
- sel_o  output  2  mux select; value is always 0, 1 or 2, never 3.
- gnt_o  output  3  one-hot grant, or 0.
- mem_en_o  output  1  memory access enable.
- done_o  output  3  one-hot completion pulse.
- busy_o  output  1  high when the state is not IDLE.
- err_o  output  1  timeout pulse; tied to 0 when the optional feature is compiled out.

Behaviour:
- Reset (asynchronous, rst_i=1): state=IDLE, sel_o=0, gnt_o=0, mem_en_o=0, done_o=0, busy_o=0, err_o=0, ptr=0, counter=0.
- All outputs are registered.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If req_i≠0, grant the first set bit searching ptr, ptr+1, ptr+2 (mod 3) as idx.
  - Next edge: sel_o=idx, gnt_o=1<<idx, mem_en_o=1, go to BUSY.
  - If req_i=0, stay in IDLE. sel_o holds its last value; gnt_o=0, mem_en_o=0.
- BUSY:
  - sel_o, gnt_o and mem_en_o are held stable.
  - On mem_ack_i=1: next edge clears gnt_o and mem_en_o, sets done_o=1<<idx, sets ptr=(idx+1) mod 3, goes to DONE.
- DONE:
  - done_o is high for exactly this one cycle.
  - Next edge: done_o=0, go to IDLE.
  - A requester must drop its req by the end of the DONE cycle. A req still high in IDLE is treated as a new request.
- Latency:
  - req sampled at edge N gives gnt_o at edge N.
  - ack sampled at edge M gives done_o at edge M.
  - Minimum 3 cycles per transaction (IDLE→BUSY→DONE).
- Boundary conditions:
  - All three req_i high continuously: grants rotate 0,1,2,0,… starting from ptr.
  - A requester dropping req during BUSY is ignored; the transaction completes and done_o still pulses.
  - mem_ack_i in IDLE or DONE is ignored and has no effect.
  - mem_ack_i in the same cycle as the BUSY entry edge: ack is sampled only from BUSY, so an ack coincident with the IDLE→BUSY edge is lost.
  - Memory must ack at least one cycle after mem_en_o rises.
  - Reset mid-BUSY: immediate return to reset values; no done_o is issued; ptr returns to 0.
  - ptr arithmetic is mod 3 only; ptr never holds 3.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - The counter clears on BUSY entry and increments each BUSY cycle without ack.
  - When counter reaches TIMEOUT with no ack, the next edge goes to DONE with done_o=0 and err_o=1 for one cycle.
  - gnt_o and mem_en_o clear, and ptr advances past idx.
  - An ack in the same cycle as the timeout wins: normal done, no err.
- Undefined: no counter logic; BUSY waits indefinitely; err_o is constant 0.

Test Plan:
- Reset check: assert rst_i asynchronously mid-cycle -> all outputs 0 immediately; sel_o=0, state IDLE.
- Single request: req_i=3'b010, ack 2 cycles after mem_en_o -> sel_o=1, gnt_o=010, mem_en_o high 3 cycles, done_o=010 for 1 cycle, busy_o low after DONE.
- Fairness: req_i=3'b111 held, ack 1 cycle after each grant -> grant order 0,1,2,0,1,2 and sel_o never 3.
- Mid-transaction drop plus late contender: grant 0, drop req_i[0] in BUSY, raise req_i[2] -> done_o=001 still issued; next grant is 2.
- Reset mid-BUSY: rst_i during BUSY with gnt_o=100 -> no done_o; with req_i=3'b101 after release, grant goes to requester 0 (ptr=0).
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=15): no ack -> err_o pulses, gnt_o=0, done_o=0; next grant goes to the following requester. With the macro undefined, the same stimulus leaves busy_o high indefinitely.
